// File: rtl/ro_reg_bank.sv
// ro_reg_bank
// Multi-channel read-only status bank. Each channel samples its status input
// every cycle into a live register. Sticky channels accumulate set bits until
// they have been reported through a read of the shadow bank. A snapshot
// request atomically copies every live register into the shadow bank. The
// shadow bank is read through a valid/ready request port with a single-entry
// response register.

module ro_reg_bank #(
    parameter int                      DATA_WIDTH   = 16,
    parameter int                      NUM_CHANNELS = 4,
    parameter int                      ADDR_WIDTH   = 2,
    parameter logic [NUM_CHANNELS-1:0] STICKY_MASK  = '0,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE  = '0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] VALUE_IN,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] VALUE_OUT,
    output logic [NUM_CHANNELS-1:0]            CHANGED,
    input  logic                               SNAPSHOT_REQ,
    output logic [7:0]                         SNAP_COUNT,
    input  logic                               RD_VALID,
    input  logic [ADDR_WIDTH-1:0]              RD_ADDR,
    output logic                               RD_READY,
    output logic                               RD_RVALID,
    output logic [DATA_WIDTH-1:0]              RD_RDATA,
    output logic                               RD_ERROR,
    input  logic                               RD_RREADY
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   r_live   [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   r_shadow [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] r_changed;
    logic [7:0]              r_snap_count;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_error;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                    w_rd_ready;
    logic                    w_accept;
    logic                    w_addr_ok;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [DATA_WIDTH-1:0]   w_clr       [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   w_live_next [NUM_CHANNELS];

    // A new request may be taken whenever the response slot is empty or is
    // being drained this cycle, which allows back-to-back accepts.
    assign w_rd_ready = !r_rvalid || RD_RREADY;
    assign w_accept   = RD_VALID && w_rd_ready;

    // Address decode: select the shadow entry and flag out-of-range indices.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the unassigned paths would infer latches.
        w_addr_ok  = 1'b0;
        w_sel_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (RD_ADDR == ADDR_WIDTH'(c)) begin
                w_addr_ok  = 1'b1;
                w_sel_data = r_shadow[c];
            end
        end
    end

    // Per-channel clear mask and next live value. Only a sticky channel that
    // is read this cycle clears, and only the bits it has just reported.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_clr[c] = '0;
            if (w_accept && STICKY_MASK[c] && (RD_ADDR == ADDR_WIDTH'(c))) begin
                w_clr[c] = r_shadow[c];
            end
            if (STICKY_MASK[c]) begin
                // Input bits high in the clearing cycle survive the clear.
                w_live_next[c] = (r_live[c] & ~w_clr[c])
                               | VALUE_IN[c*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_live_next[c] = VALUE_IN[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Live registers and their change pulses.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (RST) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_live[c] <= RESET_VALUE;
            end
            r_changed <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_live[c]    <= w_live_next[c];
                r_changed[c] <= (w_live_next[c] != r_live[c]);
            end
        end
    end

    // Shadow bank and snapshot counter. The shadow takes the registered live
    // value with just-reported bits removed, so a same-edge snapshot and read
    // never reports an event twice.
    always_ff @(posedge CLK) begin
        // NOTE: the shadow bank is a handful of flops with a defined reset
        // value, not a RAM, so it is reset along with everything else.
        if (RST) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_shadow[c] <= RESET_VALUE;
            end
            r_snap_count <= '0;
        end else if (SNAPSHOT_REQ) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_shadow[c] <= r_live[c] & ~w_clr[c];
            end
            r_snap_count <= r_snap_count + 8'd1;
        end
    end

    // Single-entry response register; data and error hold while stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else if (w_accept) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_addr_ok ? w_sel_data : '0;
            r_error  <= !w_addr_ok;
        end else if (RD_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pack
        assign VALUE_OUT[g*DATA_WIDTH +: DATA_WIDTH] = r_live[g];
    end

    assign CHANGED    = r_changed;
    assign SNAP_COUNT = r_snap_count;
    assign RD_READY   = w_rd_ready;
    assign RD_RVALID  = r_rvalid;
    assign RD_RDATA   = r_rdata;
    assign RD_ERROR   = r_error;

endmodule

// File: tb/tb_ro_reg_bank.sv
// Testbench for ro_reg_bank: three channels (ch1 sticky, ch0/ch2 live),
// directed scenarios followed by random traffic. Read responses are checked
// by a scoreboard monitor against a behavioural model of the bank.

module tb_ro_reg_bank;

    localparam int DW  = 16;
    localparam int NCH = 3;
    localparam int AW  = 2;
    localparam logic [NCH-1:0] STICKY = 3'b010;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NCH*DW-1:0]   VALUE_IN;
    logic [NCH*DW-1:0]   VALUE_OUT;
    logic [NCH-1:0]      CHANGED;
    logic                SNAPSHOT_REQ;
    logic [7:0]          SNAP_COUNT;
    logic                RD_VALID;
    logic [AW-1:0]       RD_ADDR;
    logic                RD_READY;
    logic                RD_RVALID;
    logic [DW-1:0]       RD_RDATA;
    logic                RD_ERROR;
    logic                RD_RREADY;

    ro_reg_bank #(
        .DATA_WIDTH   (DW),
        .NUM_CHANNELS (NCH),
        .ADDR_WIDTH   (AW),
        .STICKY_MASK  (STICKY),
        .RESET_VALUE  (16'h0000)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .VALUE_IN     (VALUE_IN),
        .VALUE_OUT    (VALUE_OUT),
        .CHANGED      (CHANGED),
        .SNAPSHOT_REQ (SNAPSHOT_REQ),
        .SNAP_COUNT   (SNAP_COUNT),
        .RD_VALID     (RD_VALID),
        .RD_ADDR      (RD_ADDR),
        .RD_READY     (RD_READY),
        .RD_RVALID    (RD_RVALID),
        .RD_RDATA     (RD_RDATA),
        .RD_ERROR     (RD_ERROR),
        .RD_RREADY    (RD_RREADY)
    );

    always #5 CLK = ~CLK;

    // Counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the bank
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    resp_t         sb_q [$];
    logic [DW-1:0] drv_vin   [NCH];
    logic [DW-1:0] m_live    [NCH];
    logic [DW-1:0] m_shadow  [NCH];
    logic          m_changed [NCH];
    logic          m_pend;
    logic [7:0]    m_cnt;

    function automatic logic [DW-1:0] live_ch(input int c);
        return VALUE_OUT[c*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_live[c]    = '0;
            m_shadow[c]  = '0;
            m_changed[c] = 1'b0;
        end
        m_pend = 1'b0;
        m_cnt  = '0;
        sb_q.delete();
    endtask

    // One clock cycle: drive inputs, predict the edge, then compare state.
    task automatic step(input logic snap, input logic rv, input logic [AW-1:0] addr, input logic rr);
        logic          ready, accept, ok;
        logic [DW-1:0] clr [NCH];
        logic [DW-1:0] nl;
        resp_t         r;
        for (int c = 0; c < NCH; c++) VALUE_IN[c*DW +: DW] = drv_vin[c];
        SNAPSHOT_REQ = snap;
        RD_VALID     = rv;
        RD_ADDR      = addr;
        RD_RREADY    = rr;

        ready  = !m_pend || rr;
        accept = rv && ready;
        ok     = (int'(addr) < NCH);
        #1;
        check("rd_ready", RD_READY, ready);

        if (accept) begin
            r.data = ok ? m_shadow[addr] : '0;
            r.err  = !ok;
            sb_q.push_back(r);
        end
        for (int c = 0; c < NCH; c++)
            clr[c] = (accept && ok && int'(addr) == c && STICKY[c]) ? m_shadow[c] : '0;
        if (snap) begin
            for (int c = 0; c < NCH; c++) m_shadow[c] = m_live[c] & ~clr[c];
            m_cnt = m_cnt + 8'd1;
        end
        for (int c = 0; c < NCH; c++) begin
            nl = STICKY[c] ? ((m_live[c] & ~clr[c]) | drv_vin[c]) : drv_vin[c];
            m_changed[c] = (nl != m_live[c]);
            m_live[c]    = nl;
        end
        if (accept)  m_pend = 1'b1;
        else if (rr) m_pend = 1'b0;

        @(posedge CLK);
        #1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("value_out[%0d]", c), live_ch(c), m_live[c]);
            check($sformatf("changed[%0d]", c), CHANGED[c], m_changed[c]);
        end
        check("snap_count", SNAP_COUNT, m_cnt);
        check("rd_rvalid", RD_RVALID, m_pend);
    endtask

    task automatic do_reset(input int cycles);
        RST          = 1'b1;
        SNAPSHOT_REQ = 1'b0;
        RD_VALID     = 1'b0;
        RD_ADDR      = '0;
        RD_RREADY    = 1'b0;
        for (int c = 0; c < NCH; c++) VALUE_IN[c*DW +: DW] = drv_vin[c];
        repeat (cycles) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        for (int c = 0; c < NCH; c++) check($sformatf("rst_value[%0d]", c), live_ch(c), 16'h0000);
        check("rst_changed", CHANGED, 3'b000);
        check("rst_snap_count", SNAP_COUNT, 8'd0);
        check("rst_rvalid", RD_RVALID, 1'b0);
        check("rst_rdata", RD_RDATA, 16'h0000);
        check("rst_error", RD_ERROR, 1'b0);
        check("rst_ready", RD_READY, 1'b1);
    endtask

    // Scoreboard monitor: compares each response as it is consumed.
    always @(negedge CLK) begin : monitor
        resp_t e;
        if (!RST && RD_RVALID && RD_RREADY) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got data 0x%0h err %0b, expected no response", RD_RDATA, RD_ERROR);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", RD_RDATA, e.data);
                check("rsp_error", RD_ERROR, e.err);
            end
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) drv_vin[c] = '0;
        model_reset();
        do_reset(2);

        // Idle with all inputs low
        repeat (3) step(1'b0, 1'b0, 2'd0, 1'b0);

        // Live channel 0
        drv_vin[0] = 16'h1234;
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("chg0_pulse", CHANGED[0], 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check("snap_one", SNAP_COUNT, 8'd1);
        step(1'b0, 1'b1, 2'd0, 1'b1);
        check("rd0_data", RD_RDATA, 16'h1234);
        check("rd0_error", RD_ERROR, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1);

        // Sticky channel 1 accumulation and clear-on-read
        drv_vin[1] = 16'h0001; step(1'b0, 1'b0, 2'd0, 1'b0);
        drv_vin[1] = 16'h0100; step(1'b0, 1'b0, 2'd0, 1'b0);
        drv_vin[1] = 16'h0000; step(1'b0, 1'b0, 2'd0, 1'b0);
        check("sticky_acc", live_ch(1), 16'h0101);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 1'b1);
        check("sticky_rd", RD_RDATA, 16'h0101);
        check("sticky_cleared", live_ch(1), 16'h0000);
        step(1'b0, 1'b0, 2'd0, 1'b1);

        // Input bit high during the clearing read is retained
        drv_vin[1] = 16'h0101; step(1'b0, 1'b0, 2'd0, 1'b0);
        drv_vin[1] = 16'h0000; step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        drv_vin[1] = 16'h0001; step(1'b0, 1'b1, 2'd1, 1'b1);
        check("sticky_retain", live_ch(1), 16'h0001);
        drv_vin[1] = 16'h0000; step(1'b0, 1'b0, 2'd0, 1'b1);

        // Same-edge snapshot and sticky read: shadow 1, live 3
        step(1'b1, 1'b0, 2'd0, 1'b0);
        drv_vin[1] = 16'h0002; step(1'b0, 1'b0, 2'd0, 1'b0);
        drv_vin[1] = 16'h0000;
        check("same_edge_live_pre", live_ch(1), 16'h0003);
        step(1'b1, 1'b1, 2'd1, 1'b1);
        check("same_edge_rsp", RD_RDATA, 16'h0001);
        check("same_edge_live", live_ch(1), 16'h0002);
        step(1'b0, 1'b1, 2'd1, 1'b1);
        check("same_edge_shadow", RD_RDATA, 16'h0002);
        check("same_edge_live_clr", live_ch(1), 16'h0000);
        step(1'b0, 1'b0, 2'd0, 1'b1);

        // Out-of-range address
        step(1'b0, 1'b1, 2'd3, 1'b1);
        check("oor_error", RD_ERROR, 1'b1);
        check("oor_rdata", RD_RDATA, 16'h0000);
        step(1'b0, 1'b0, 2'd0, 1'b1);

        // Backpressure: response held for 5 cycles
        step(1'b0, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 2'd2, 1'b0);
            check("bp_ready", RD_READY, 1'b0);
            check("bp_hold_data", RD_RDATA, 16'h1234);
            check("bp_hold_error", RD_ERROR, 1'b0);
        end
        step(1'b0, 1'b0, 2'd0, 1'b1);

        // Reset with a response pending
        step(1'b0, 1'b1, 2'd0, 1'b0);
        for (int c = 0; c < NCH; c++) drv_vin[c] = '0;
        do_reset(1);

        // Snapshot counter wrap
        repeat (256) step(1'b1, 1'b0, 2'd0, 1'b0);
        check("snap_wrap", SNAP_COUNT, 8'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drv_vin[0] = 16'($urandom);
            drv_vin[2] = 16'($urandom);
            drv_vin[1] = ($urandom_range(3, 0) == 0) ? (16'h0001 << $urandom_range(15, 0)) : 16'h0000;
            step($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1,
                 2'($urandom_range(3, 0)), $urandom_range(3, 0) != 0);
        end

        // Drain any outstanding response within a bounded number of cycles
        for (int i = 0; i < 10 && m_pend; i++) step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("drain_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
